// File: rtl/avalon_xbar_pkg.sv
// ---------------------------------------------------------------------------
// avalon_xbar_pkg
// Shared definitions for the Avalon crossbar arbiter:
//   - default port counts for the 5x5 crossbar
//   - sel_width(): width of one mux-select field; it holds 0..NUM_MASTERS,
//     where NUM_MASTERS means "terminated, no master"
//   - SEL_NONE: the terminated select code for the default crossbar
//   - slot_state_e: per-slave FSM states
// ---------------------------------------------------------------------------
package avalon_xbar_pkg;

    localparam int NUM_MASTERS_DEF = 5;
    localparam int NUM_SLAVES_DEF  = 5;

    function automatic int sel_width(input int num_masters);
        return $clog2(num_masters + 1);
    endfunction

    localparam int SEL_W_DEF = sel_width(NUM_MASTERS_DEF);
    localparam int SEL_NONE  = NUM_MASTERS_DEF;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } slot_state_e;

endpackage

// File: rtl/avalon_xbar_slot_arb.sv
// ---------------------------------------------------------------------------
// avalon_xbar_slot_arb
// Arbiter for one crossbar slave port. A round-robin search picks a master
// among the unmasked requesters, and the grant is then held until the
// transaction's last beat is accepted or the master abandons the request
// before starting.
// Ports:
//   i_Clk, i_Rst       clock, synchronous active-high reset
//   i_Req              per-master request for this slave
//   i_Mask             masters unavailable this cycle (granted elsewhere or
//                      taken by a lower-index slave in the same cycle)
//   i_Read/i_Write     per-master read/write strobes
//   i_BurstCount       per-master burst count, field m at [8m+:8]
//   i_WaitRequest      this slave's waitrequest
//   o_Win              one-hot master won this cycle (combinational, IDLE only)
//   o_Held             one-hot master currently granted (from registers)
//   o_MuxSel           registered select, NUM_MASTERS when terminated
//   o_Busy             registered, high while a grant is held
// ---------------------------------------------------------------------------
import avalon_xbar_pkg::*;

module avalon_xbar_slot_arb #(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int SEL_W       = sel_width(NUM_MASTERS)
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic [NUM_MASTERS-1:0]   i_Req,
    input  logic [NUM_MASTERS-1:0]   i_Mask,
    input  logic [NUM_MASTERS-1:0]   i_Read,
    input  logic [NUM_MASTERS-1:0]   i_Write,
    input  logic [8*NUM_MASTERS-1:0] i_BurstCount,
    input  logic                     i_WaitRequest,
    output logic [NUM_MASTERS-1:0]   o_Win,
    output logic [NUM_MASTERS-1:0]   o_Held,
    output logic [SEL_W-1:0]         o_MuxSel,
    output logic                     o_Busy
);

    localparam logic [SEL_W-1:0] SEL_TERM = SEL_W'(NUM_MASTERS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_MASTERS - 1);

    slot_state_e      r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_rr;
    logic [7:0]       r_cnt;
    logic [7:0]       r_len;
    logic             r_st;

    logic [NUM_MASTERS-1:0] w_cand;
    logic                   w_found;
    logic [SEL_W-1:0]       w_winner;
    logic [NUM_MASTERS-1:0] w_held;
    logic                   w_rw;
    logic                   w_req_g;
    logic                   w_acc;
    logic [7:0]             w_bc;
    logic [7:0]             w_bc_eff;
    logic [7:0]             w_len_eff;
    logic                   w_last;

    assign w_cand = i_Req & ~i_Mask;

    // Round-robin: the winner is the candidate with the smallest forward
    // distance from the pointer, which equals a wrapping search from r_rr.
    always_comb begin
        int best_d;
        int d;
        w_found  = 1'b0;
        w_winner = '0;
        best_d   = NUM_MASTERS;
        d        = 0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            d = (m >= int'(r_rr)) ? (m - int'(r_rr)) : (m + NUM_MASTERS - int'(r_rr));
            if (w_cand[m] && d < best_d) begin
                best_d   = d;
                w_found  = 1'b1;
                w_winner = SEL_W'(m);
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            o_Win[m] = (r_state == IDLE) && w_found && (w_winner == SEL_W'(m));
        end
    end

    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_held[m] = (r_state == GRANTED) && (r_sel == SEL_W'(m));
        end
    end

    assign o_Held = w_held;

    // Signals of the granted master, selected through the one-hot grant so
    // the terminated select code never indexes past the master vectors.
    always_comb begin
        w_bc = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (w_held[m]) w_bc = i_BurstCount[8*m +: 8];
        end
    end

    assign w_rw      = |((i_Read | i_Write) & w_held);
    assign w_req_g   = |(i_Req & w_held);
    assign w_acc     = w_rw & ~i_WaitRequest;
    assign w_bc_eff  = (w_bc == 8'd0) ? 8'd1 : w_bc;
    // Before the length is latched, the current burst count is the length.
    assign w_len_eff = r_st ? r_len : w_bc_eff;
    assign w_last    = ({1'b0, r_cnt} + 9'd1) == {1'b0, w_len_eff};

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= IDLE;
            r_sel   <= SEL_TERM;
            r_rr    <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_st    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANTED;
                        r_sel   <= w_winner;
                        r_rr    <= (w_winner == SEL_LAST) ? '0 : w_winner + SEL_W'(1);
                        r_cnt   <= '0;
                        r_st    <= 1'b0;
                    end
                end
                GRANTED: begin
                    if (!r_st && !w_req_g) begin
                        // Request withdrawn before any read/write: abandon.
                        r_state <= IDLE;
                        r_sel   <= SEL_TERM;
                        r_cnt   <= '0;
                    end else begin
                        if (!r_st && w_rw) begin
                            r_len <= w_bc_eff;
                            r_st  <= 1'b1;
                        end
                        if (w_acc) begin
                            if (w_last) begin
                                r_state <= IDLE;
                                r_sel   <= SEL_TERM;
                                r_cnt   <= '0;
                                r_st    <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sel   <= SEL_TERM;
                end
            endcase
        end
    end

    assign o_MuxSel = r_sel;
    assign o_Busy   = (r_state == GRANTED);

endmodule

// File: rtl/avalon_xbar_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_xbar_arbiter
// Per-slave round-robin arbiters driving the crossbar mux-select bus. One
// slot arbiter per slave; this level builds the cross-slave mask so a
// master is granted on at most one slave at a time.
// Ports:
//   i_Clk, i_Rst          clock, synchronous active-high reset
//   i_M_SReq              bit m*NUM_SLAVES+s = master m requests slave s
//   i_AVIn_Read/_Write    per-master strobes
//   i_AVIn_BurstCount     per-master burst count, field m at [8m+:8]
//   i_AVOut_WaitRequest   per-slave waitrequest
//   o_MuxSel              field s = granted master, NUM_MASTERS if none
//   o_Busy                bit s high while slave s holds a grant
// ---------------------------------------------------------------------------
import avalon_xbar_pkg::*;

module avalon_xbar_arbiter #(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int NUM_SLAVES  = NUM_SLAVES_DEF,
    parameter int SEL_W       = sel_width(NUM_MASTERS)
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst,
    input  logic [NUM_MASTERS*NUM_SLAVES-1:0] i_M_SReq,
    input  logic [NUM_MASTERS-1:0]            i_AVIn_Read,
    input  logic [NUM_MASTERS-1:0]            i_AVIn_Write,
    input  logic [8*NUM_MASTERS-1:0]          i_AVIn_BurstCount,
    input  logic [NUM_SLAVES-1:0]             i_AVOut_WaitRequest,
    output logic [SEL_W*NUM_SLAVES-1:0]       o_MuxSel,
    output logic [NUM_SLAVES-1:0]             o_Busy
);

    logic [NUM_MASTERS-1:0] w_held [NUM_SLAVES];
    logic [NUM_MASTERS-1:0] w_held_any;

    always_comb begin
        w_held_any = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            w_held_any = w_held_any | w_held[s];
        end
    end

    // Each slot sees masters held anywhere plus masters won this cycle by
    // lower-index slaves; the accumulation ripples from slave 0 upward.
    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slot
        logic [NUM_MASTERS-1:0] w_req;
        logic [NUM_MASTERS-1:0] w_prev_win;
        logic [NUM_MASTERS-1:0] w_mask;
        logic [NUM_MASTERS-1:0] w_win;
        logic [NUM_MASTERS-1:0] w_win_acc;

        always_comb begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                w_req[m] = i_M_SReq[m*NUM_SLAVES + s];
            end
        end

        if (s == 0) begin : g_first
            assign w_prev_win = '0;
        end else begin : g_next
            assign w_prev_win = g_slot[s-1].w_win_acc;
        end

        assign w_mask    = w_held_any | w_prev_win;
        assign w_win_acc = w_prev_win | w_win;

        avalon_xbar_slot_arb #(
            .NUM_MASTERS (NUM_MASTERS),
            .SEL_W       (SEL_W)
        ) u_slot (
            .i_Clk         (i_Clk),
            .i_Rst         (i_Rst),
            .i_Req         (w_req),
            .i_Mask        (w_mask),
            .i_Read        (i_AVIn_Read),
            .i_Write       (i_AVIn_Write),
            .i_BurstCount  (i_AVIn_BurstCount),
            .i_WaitRequest (i_AVOut_WaitRequest[s]),
            .o_Win         (w_win),
            .o_Held        (w_held[s]),
            .o_MuxSel      (o_MuxSel[s*SEL_W +: SEL_W]),
            .o_Busy        (o_Busy[s])
        );
    end

endmodule

// File: tb/tb_avalon_xbar_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_xbar_arbiter
// Directed scenarios for the 5x5 crossbar arbiter with hand-derived selects.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, so each check reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_avalon_xbar_arbiter;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic [24:0] i_M_SReq;
    logic [4:0]  i_AVIn_Read;
    logic [4:0]  i_AVIn_Write;
    logic [39:0] i_AVIn_BurstCount;
    logic [4:0]  i_AVOut_WaitRequest;
    logic [14:0] o_MuxSel;
    logic [4:0]  o_Busy;

    int total = 0;
    int bad   = 0;

    localparam logic [14:0] ALL_TERM = {5{3'd5}};

    avalon_xbar_arbiter dut (
        .i_Clk               (i_Clk),
        .i_Rst               (i_Rst),
        .i_M_SReq            (i_M_SReq),
        .i_AVIn_Read         (i_AVIn_Read),
        .i_AVIn_Write        (i_AVIn_Write),
        .i_AVIn_BurstCount   (i_AVIn_BurstCount),
        .i_AVOut_WaitRequest (i_AVOut_WaitRequest),
        .o_MuxSel            (o_MuxSel),
        .o_Busy              (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [2:0] sel(input int s);
        return o_MuxSel[s*3 +: 3];
    endfunction

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic set_req(input int m, input int s, input logic v);
        i_M_SReq[m*5 + s] = v;
    endtask

    task automatic clear_inputs();
        i_M_SReq            = '0;
        i_AVIn_Read         = '0;
        i_AVIn_Write        = '0;
        i_AVIn_BurstCount   = '0;
        i_AVOut_WaitRequest = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (o_MuxSel !== ALL_TERM) begin bad++; $display("FAIL reset_sel got=%h exp=%h", o_MuxSel, ALL_TERM); end
        total++; if (o_Busy !== 5'b0) begin bad++; $display("FAIL reset_busy got=%b exp=%b", o_Busy, 5'b0); end
        tick();
        total++; if (o_MuxSel !== ALL_TERM) begin bad++; $display("FAIL idle_sel got=%h exp=%h", o_MuxSel, ALL_TERM); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(2, 1, 1'b1);
        i_AVIn_Write[2] = 1'b1;
        i_AVIn_BurstCount[2*8 +: 8] = 8'd8;
        tick();                                   // grant
        total++; if (sel(1) !== 3'd2) begin bad++; $display("FAIL rmb_grant got=%0d exp=%0d", sel(1), 2); end
        for (int i = 0; i < 3; i++) tick();       // three beats accepted
        total++; if (sel(1) !== 3'd2) begin bad++; $display("FAIL rmb_3beats got=%0d exp=%0d", sel(1), 2); end
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        total++; if (o_MuxSel !== ALL_TERM) begin bad++; $display("FAIL rmb_rst_sel got=%h exp=%h", o_MuxSel, ALL_TERM); end
        total++; if (o_Busy !== 5'b0) begin bad++; $display("FAIL rmb_rst_busy got=%b exp=%b", o_Busy, 5'b0); end
        tick();                                   // re-grant
        total++; if (sel(1) !== 3'd2) begin bad++; $display("FAIL rmb_regrant got=%0d exp=%0d", sel(1), 2); end
        total++; if (o_Busy !== 5'b00010) begin bad++; $display("FAIL rmb_regrant_busy got=%b exp=%b", o_Busy, 5'b00010); end
        for (int i = 0; i < 7; i++) tick();       // beats 1..7 of a fresh 8
        total++; if (sel(1) !== 3'd2) begin bad++; $display("FAIL rmb_beat7 got=%0d exp=%0d", sel(1), 2); end
        tick();                                   // beat 8
        total++; if (sel(1) !== 3'd5) begin bad++; $display("FAIL rmb_done got=%0d exp=%0d", sel(1), 5); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [8];
        exp_seq = '{3'd0, 3'd5, 3'd1, 3'd5, 3'd3, 3'd5, 3'd0, 3'd5};
        do_reset();
        set_req(0, 0, 1'b1);
        set_req(1, 0, 1'b1);
        set_req(3, 0, 1'b1);
        i_AVIn_Write = 5'b01011;
        i_AVIn_BurstCount = {8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (sel(0) !== exp_seq[i]) begin bad++; $display("FAIL rr_step%0d got=%0d exp=%0d", i, sel(0), exp_seq[i]); end
        end
        total++; if (o_Busy !== 5'b0) begin bad++; $display("FAIL rr_busy_end got=%b exp=%b", o_Busy, 5'b0); end
    endtask

    task automatic test_burst_lock();
        logic       wpat [8];
        logic [2:0] exp;
        wpat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        set_req(4, 2, 1'b1);
        i_AVIn_Write[4] = 1'b1;
        i_AVIn_BurstCount[4*8 +: 8] = 8'd4;
        tick();
        total++; if (sel(2) !== 3'd4) begin bad++; $display("FAIL bl_grant got=%0d exp=%0d", sel(2), 4); end
        set_req(0, 2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            i_AVOut_WaitRequest[2] = wpat[i];
            tick();
            exp = (i == 7) ? 3'd5 : 3'd4;
            total++; if (sel(2) !== exp) begin bad++; $display("FAIL bl_cyc%0d got=%0d exp=%0d", i, sel(2), exp); end
        end
        i_AVIn_Write[4] = 1'b0;
        set_req(4, 2, 1'b0);
        i_AVOut_WaitRequest[2] = 1'b0;
        tick();
        total++; if (sel(2) !== 3'd0) begin bad++; $display("FAIL bl_next got=%0d exp=%0d", sel(2), 0); end
    endtask

    task automatic test_abandon();
        do_reset();
        set_req(1, 3, 1'b1);
        tick();
        total++; if (sel(3) !== 3'd1) begin bad++; $display("FAIL ab_grant got=%0d exp=%0d", sel(3), 1); end
        total++; if (o_Busy !== 5'b01000) begin bad++; $display("FAIL ab_busy got=%b exp=%b", o_Busy, 5'b01000); end
        set_req(1, 3, 1'b0);
        tick();
        total++; if (sel(3) !== 3'd5) begin bad++; $display("FAIL ab_release got=%0d exp=%0d", sel(3), 5); end
        total++; if (o_Busy !== 5'b0) begin bad++; $display("FAIL ab_busy_rel got=%b exp=%b", o_Busy, 5'b0); end
    endtask

    task automatic test_cross_slave();
        do_reset();
        set_req(2, 0, 1'b1);
        set_req(2, 4, 1'b1);
        set_req(3, 4, 1'b1);
        tick();
        total++; if (sel(0) !== 3'd2) begin bad++; $display("FAIL cs_s0 got=%0d exp=%0d", sel(0), 2); end
        total++; if (sel(4) !== 3'd3) begin bad++; $display("FAIL cs_s4_other got=%0d exp=%0d", sel(4), 3); end
        do_reset();
        set_req(2, 0, 1'b1);
        set_req(2, 4, 1'b1);
        tick();
        total++; if (sel(0) !== 3'd2) begin bad++; $display("FAIL cs_s0_alone got=%0d exp=%0d", sel(0), 2); end
        total++; if (sel(4) !== 3'd5) begin bad++; $display("FAIL cs_s4_term got=%0d exp=%0d", sel(4), 5); end
        tick();
        total++; if (sel(4) !== 3'd5) begin bad++; $display("FAIL cs_s4_masked got=%0d exp=%0d", sel(4), 5); end
    endtask

    task automatic test_burstcount0();
        do_reset();
        set_req(3, 1, 1'b1);
        i_AVIn_BurstCount[3*8 +: 8] = 8'd0;
        tick();
        total++; if (sel(1) !== 3'd3) begin bad++; $display("FAIL bc0_grant got=%0d exp=%0d", sel(1), 3); end
        i_AVIn_Read[3] = 1'b1;
        tick();
        total++; if (sel(1) !== 3'd5) begin bad++; $display("FAIL bc0_release got=%0d exp=%0d", sel(1), 5); end
        // Same again with the first read stalled: length latched while waiting.
        do_reset();
        set_req(3, 1, 1'b1);
        tick();
        i_AVIn_Read[3] = 1'b1;
        i_AVOut_WaitRequest[1] = 1'b1;
        tick();
        total++; if (sel(1) !== 3'd3) begin bad++; $display("FAIL bc0_stall got=%0d exp=%0d", sel(1), 3); end
        i_AVOut_WaitRequest[1] = 1'b0;
        tick();
        total++; if (sel(1) !== 3'd5) begin bad++; $display("FAIL bc0_stall_rel got=%0d exp=%0d", sel(1), 5); end
    endtask

    task automatic test_long_burst();
        do_reset();
        set_req(0, 0, 1'b1);
        i_AVIn_Write[0] = 1'b1;
        i_AVIn_BurstCount[0 +: 8] = 8'd255;
        tick();
        for (int i = 0; i < 254; i++) tick();
        total++; if (sel(0) !== 3'd0) begin bad++; $display("FAIL lb_254 got=%0d exp=%0d", sel(0), 0); end
        tick();
        total++; if (sel(0) !== 3'd5) begin bad++; $display("FAIL lb_255 got=%0d exp=%0d", sel(0), 5); end
    endtask

    initial begin
        clear_inputs();
        i_Rst = 1'b1;
        tick();
        test_reset();
        test_reset_mid_burst();
        test_round_robin();
        test_burst_lock();
        test_abandon();
        test_cross_slave();
        test_burstcount0();
        test_long_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
